// File: rtl/axi_hbm_resp.sv
// ---------------------------------------------------------------------------
// axi_hbm_resp
// AXI4 slave that emulates a single 256-bit HBM pseudo-channel. The backing
// store holds 2^MEM_ADDR_BITS words of 256 bits each. Reads and writes run
// through independent state machines.
//
// Ports
//   aclk, areset          : clock and synchronous active-high reset
//   s_axi_ar*             : read address channel (cache/lock/prot/qos/region
//                           are accepted but ignored)
//   s_axi_r*              : read data channel, first beat two cycles after AR
//   s_axi_aw*             : write address channel (sideband fields ignored)
//   s_axi_w*              : write data channel with per-byte strobes
//   s_axi_b*              : write response channel
//
// Only INCR bursts of full 32-byte beats inside the memory window are served.
// Any other request is still completed with the right beat count, but it
// answers SLVERR, returns zero read data and stores nothing.
// ---------------------------------------------------------------------------
module axi_hbm_resp #(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic         aclk,
    input  logic         areset,

    input  logic [63:0]  s_axi_araddr,
    input  logic [1:0]   s_axi_arburst,
    input  logic [0:0]   s_axi_arid,
    input  logic [7:0]   s_axi_arlen,
    input  logic [2:0]   s_axi_arsize,
    input  logic [3:0]   s_axi_arcache,
    input  logic [0:0]   s_axi_arlock,
    input  logic [2:0]   s_axi_arprot,
    input  logic [3:0]   s_axi_arqos,
    input  logic [3:0]   s_axi_arregion,
    input  logic         s_axi_arvalid,
    output logic         s_axi_arready,

    input  logic [63:0]  s_axi_awaddr,
    input  logic [1:0]   s_axi_awburst,
    input  logic [0:0]   s_axi_awid,
    input  logic [7:0]   s_axi_awlen,
    input  logic [2:0]   s_axi_awsize,
    input  logic [3:0]   s_axi_awcache,
    input  logic [0:0]   s_axi_awlock,
    input  logic [2:0]   s_axi_awprot,
    input  logic [3:0]   s_axi_awqos,
    input  logic [3:0]   s_axi_awregion,
    input  logic         s_axi_awvalid,
    output logic         s_axi_awready,

    output logic [255:0] s_axi_rdata,
    output logic [0:0]   s_axi_rid,
    output logic         s_axi_rlast,
    output logic [1:0]   s_axi_rresp,
    output logic         s_axi_rvalid,
    input  logic         s_axi_rready,

    input  logic [255:0] s_axi_wdata,
    input  logic [31:0]  s_axi_wstrb,
    input  logic         s_axi_wlast,
    input  logic         s_axi_wvalid,
    output logic         s_axi_wready,

    output logic [0:0]   s_axi_bid,
    output logic [1:0]   s_axi_bresp,
    output logic         s_axi_bvalid,
    input  logic         s_axi_bready
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam logic [MEM_ADDR_BITS-1:0] IDX_ONE = 1;

    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_ACTIVE = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // A request is served only as an INCR burst of 32-byte beats whose
    // address lies entirely inside the memory window.
    function automatic logic req_bad(input logic [63:0] addr,
                                     input logic [1:0]  burst,
                                     input logic [2:0]  size);
        return (burst != 2'b01) || (size != 3'b101) ||
               (|addr[63:5+MEM_ADDR_BITS]);
    endfunction

    // Sideband fields and sub-word address bits have no effect.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_arcache, s_axi_arlock, s_axi_arprot,
                             s_axi_arqos, s_axi_arregion,
                             s_axi_awcache, s_axi_awlock, s_axi_awprot,
                             s_axi_awqos, s_axi_awregion,
                             s_axi_araddr[4:0], s_axi_awaddr[4:0]};

    // ------------------------------------------------------------- read side
    logic [0:0]               r_state_reg;
    logic [MEM_ADDR_BITS-1:0] r_idx_reg;     // next word to fetch
    logic [8:0]               r_remain_reg;  // beats still to fetch
    logic                     rvalid_reg;
    logic                     rlast_reg;
    logic                     rbad_reg;
    logic [0:0]               rid_reg;
    logic [255:0]             mem_q;

    logic ar_hs;
    logic r_hs;
    logic r_fetch;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = rvalid_reg && s_axi_rready;
    // The RAM output register doubles as the R data register: a new word is
    // fetched only when the current one is absent or leaving this cycle, so
    // the beat on the bus stays frozen while the master stalls.
    assign r_fetch = (r_state_reg == R_ACTIVE) && (r_remain_reg != 9'd0) &&
                     (!rvalid_reg || s_axi_rready);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_reg  <= R_IDLE;
            r_idx_reg    <= '0;
            r_remain_reg <= '0;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rbad_reg     <= 1'b0;
            rid_reg      <= '0;
        end else if (r_state_reg == R_IDLE) begin
            if (ar_hs) begin
                r_state_reg  <= R_ACTIVE;
                r_idx_reg    <= s_axi_araddr[5 +: MEM_ADDR_BITS];
                r_remain_reg <= {1'b0, s_axi_arlen} + 9'd1;
                rbad_reg     <= req_bad(s_axi_araddr, s_axi_arburst, s_axi_arsize);
                rid_reg      <= s_axi_arid;
            end
        end else begin
            if (r_fetch) begin
                r_idx_reg    <= r_idx_reg + IDX_ONE;
                r_remain_reg <= r_remain_reg - 9'd1;
                rvalid_reg   <= 1'b1;
                rlast_reg    <= (r_remain_reg == 9'd1);
            end else if (r_hs) begin
                rvalid_reg <= 1'b0;
                if (rlast_reg) begin
                    r_state_reg <= R_IDLE;
                    rlast_reg   <= 1'b0;
                end
            end
        end
    end

    assign s_axi_arready = !areset && (r_state_reg == R_IDLE);
    assign s_axi_rvalid  = !areset && rvalid_reg;
    assign s_axi_rlast   = s_axi_rvalid && rlast_reg;
    assign s_axi_rresp   = (s_axi_rvalid && rbad_reg) ? 2'b10 : 2'b00;
    assign s_axi_rdata   = (s_axi_rvalid && !rbad_reg) ? mem_q : '0;
    assign s_axi_rid     = rid_reg;

    // ------------------------------------------------------------ write side
    logic [1:0]               w_state_reg;
    logic [MEM_ADDR_BITS-1:0] w_idx_reg;
    logic [8:0]               w_remain_reg;  // beats still expected, incl. current
    logic                     wbad_reg;
    logic                     werr_reg;      // sticky wlast misplacement
    logic [0:0]               bid_reg;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic w_final;
    logic w_we;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign b_hs    = s_axi_bvalid && s_axi_bready;
    assign w_final = (w_remain_reg == 9'd1);
    assign w_we    = w_hs && !wbad_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_reg  <= W_IDLE;
            w_idx_reg    <= '0;
            w_remain_reg <= '0;
            wbad_reg     <= 1'b0;
            werr_reg     <= 1'b0;
            bid_reg      <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_state_reg  <= W_DATA;
                        w_idx_reg    <= s_axi_awaddr[5 +: MEM_ADDR_BITS];
                        w_remain_reg <= {1'b0, s_axi_awlen} + 9'd1;
                        wbad_reg     <= req_bad(s_axi_awaddr, s_axi_awburst, s_axi_awsize);
                        werr_reg     <= 1'b0;
                        bid_reg      <= s_axi_awid;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_idx_reg    <= w_idx_reg + IDX_ONE;
                        w_remain_reg <= w_remain_reg - 9'd1;
                        // The burst length comes from awlen; wlast only
                        // has to agree with it.
                        if (s_axi_wlast != w_final) begin
                            werr_reg <= 1'b1;
                        end
                        if (w_final) begin
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready = !areset && (w_state_reg == W_IDLE);
    assign s_axi_wready  = !areset && (w_state_reg == W_DATA);
    assign s_axi_bvalid  = !areset && (w_state_reg == W_RESP);
    assign s_axi_bresp   = (s_axi_bvalid && (wbad_reg || werr_reg)) ? 2'b10 : 2'b00;
    assign s_axi_bid     = bid_reg;

    // ---------------------------------------------------------------- memory
    // One byte-wide RAM per strobe lane. Read and write share a clock edge
    // with non-blocking updates, so a same-word collision returns old data.
    for (genvar gi = 0; gi < 32; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q;

        always_ff @(posedge aclk) begin
            if (w_we && s_axi_wstrb[gi]) begin
                lane_mem[w_idx_reg] <= s_axi_wdata[gi*8 +: 8];
            end
            if (r_fetch) begin
                lane_q <= lane_mem[r_idx_reg];
            end
        end

        assign mem_q[gi*8 +: 8] = lane_q;
    end

endmodule
